switch_command_receiver: RTL
============================

// Module: switch_command_receiver
// PURPOSE
//  Receive side of the board-switch interface: samples the four raw switches, debounces them,
//  and issues clean one-cycle move commands plus a chord-reset request. Sits between the board
//  pins and the frog movement / game-reset logic; replaces direct raw-switch use in the frogger top.
// PARAMETERS
//  DEBOUNCE_CYCLES   250000  consecutive equal samples needed to accept a new level (10 ms @ 25 MHz)
//  CHORD_HOLD_CYCLES 500000  cycles all four stable-high before chord_reset fires
//  REPEAT_DELAY      6250000 cycles a single held switch waits before the first repeat (AUTOREPEAT_EN only)
//  REPEAT_PERIOD     2500000 cycles between later repeats (AUTOREPEAT_EN only)
//  CNT_W             23      counter width; must hold the largest parameter
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  switch1..4   in   1  raw switches (up, down, left, right), asynchronous to clk
//  move_up      out  1  one-cycle move command
//  move_down    out  1  one-cycle move command
//  move_left    out  1  one-cycle move command
//  move_right   out  1  one-cycle move command
//  chord_reset  out  1  one-cycle game-reset request
//  sw_stable    out  4  debounced levels {right,left,down,up}
// BEHAVIOUR
//  - Reset: all outputs 0, sync/debounce state 0, counters 0, FSM IDLE. Reset mid-press: a switch
//    already held at release of reset counts as a new press once debounced.
//  - Each input: 2-FF synchroniser -> debouncer. The counter clears when the sample differs from
//    sw_stable. When it reaches DEBOUNCE_CYCLES-1 with the sample still different, sw_stable takes
//    the new level and the counter clears.
//  - Press = 0->1 on sw_stable. The move pulse is registered one cycle after the sw_stable change.
//    Raw-edge-to-pulse latency = 2 + DEBOUNCE_CYCLES + 1 cycles.
//  - Move outputs are one-hot or zero. On simultaneous presses, priority is up > down > left > right.
//    Losing presses are discarded and never replayed.
//  - Releases produce no output.
//  - FSM (evaluated on sw_stable):
//    IDLE:       no switch high. Press of one switch -> pulse, go to HELD. All four high -> CHORD_WAIT.
//    HELD:       >=1 high, not all four. A new press of another switch -> pulse (priority rule), stay.
//                All four high -> CHORD_WAIT. None high -> IDLE.
//    CHORD_WAIT: all four high; moves suppressed; hold counter runs.
//                Counter reaches CHORD_HOLD_CYCLES-1 -> chord_reset pulse, go to LOCKOUT.
//                Any switch drops first -> counter clears, go to HELD (or IDLE if none high), no pulse.
//    LOCKOUT:    all outputs 0 until every switch is stable-low, then IDLE.
//                A press in the same cycle as that exit is not lost: it is handled in IDLE next cycle.
//  - The fourth switch of a chord gives no move pulse. Switches 1-3 pressed on the way into a chord
//    do give move pulses.
//  - Counters saturate; they never wrap.
// CONFIGURATION
//  AUTOREPEAT_EN defined: in HELD with exactly one switch high, a repeat counter starts at the press.
//    The first repeat pulse fires at REPEAT_DELAY cycles, then one every REPEAT_PERIOD cycles.
//    Any sw_stable change clears the counter; a new press restarts it.
//  AUTOREPEAT_EN undefined: exactly one pulse per press; the repeat counter and its parameters are
//    not synthesised.
// STRUCTURE
//  - Shared package frogger_pkg: direction index constants (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2,
//    DIR_RIGHT=3) and FSM state encodings (IDLE, HELD, CHORD_WAIT, LOCKOUT), 2 bits.
//  - Sub-module switch_debouncer, instantiated four times: synchroniser + counter + stable output,
//    parameter DEBOUNCE_CYCLES.
//  - Press detection, priority, FSM, chord counter and repeat counter live in this module.
// TESTING (DEBOUNCE_CYCLES=4, CHORD_HOLD_CYCLES=8, REPEAT_DELAY=10, REPEAT_PERIOD=5)
//  1. switch1 rises, held 20 cycles -> move_up high exactly 1 cycle, 7 cycles after the raw edge.
//     Without AUTOREPEAT_EN nothing more; with it, repeats 10 and 15 cycles after the first pulse.
//  2. switch3 toggles every 2 cycles for 30 cycles, then settles high -> no pulse while toggling;
//     one move_left after settling.
//  3. switch2 and switch4 rise in the same cycle -> single move_down; move_right never asserted.
//  4. switch1..4 rise together, held 20 cycles -> no move pulses; chord_reset once, 8 cycles after
//     sw_stable=4'hF; outputs silent until all released.
//  5. All four held 5 cycles, switch4 released -> no chord_reset, FSM in HELD.
//     Re-press switch4 -> no move_right, chord timer restarts from 0.
//  6. reset asserted mid-CHORD_WAIT -> all outputs 0 asynchronously. Release reset with switch2
//     held -> one move_down after 2+4+1 cycles.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared definitions for the frogger switch path: direction indices,
// command-FSM state encodings and the move priority helper.
`timescale 1ns/1ps
package frogger_pkg;

    // Bit positions of each direction in the 4-bit switch/move vectors.
    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    // Command FSM state encodings.
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] HELD       = 2'd1;
    localparam logic [1:0] CHORD_WAIT = 2'd2;
    localparam logic [1:0] LOCKOUT    = 2'd3;

    // Keep only the highest-priority request: up > down > left > right.
    function automatic logic [3:0] priority_pick(input logic [3:0] req);
        logic [3:0] pick;
        pick = 4'b0000;
        if (req[DIR_UP])         pick[DIR_UP]    = 1'b1;
        else if (req[DIR_DOWN])  pick[DIR_DOWN]  = 1'b1;
        else if (req[DIR_LEFT])  pick[DIR_LEFT]  = 1'b1;
        else if (req[DIR_RIGHT]) pick[DIR_RIGHT] = 1'b1;
        return pick;
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// One raw switch: 2-FF synchroniser followed by a consecutive-sample
// debouncer. The stable level only changes after DEBOUNCE_CYCLES
// consecutive synchronised samples disagree with it.
`timescale 1ns/1ps
module switch_debouncer
    import frogger_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 23
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive samples that disagree with the stable level; accept
    // the new level on the last one. The counter never passes CNT_LAST.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Synchroniser, counter and stable level registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sw_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sw_stable = stable_q;

endmodule

// File: rtl/switch_command_receiver.sv
// Receive side of the board-switch interface. Debounces the four switches
// and turns stable presses into one-cycle move commands, plus a chord-reset
// request when all four are held long enough.
// Optional feature: define AUTOREPEAT_EN to add auto-repeat of a single
// held direction (REPEAT_DELAY / REPEAT_PERIOD exist only in that build).
`timescale 1ns/1ps
module switch_command_receiver
    import frogger_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 250000,
    parameter int unsigned CHORD_HOLD_CYCLES = 500000,
`ifdef AUTOREPEAT_EN
    parameter int unsigned REPEAT_DELAY      = 6250000,
    parameter int unsigned REPEAT_PERIOD     = 2500000,
`endif
    parameter int unsigned CNT_W             = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       switch1,
    input  logic       switch2,
    input  logic       switch3,
    input  logic       switch4,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic       chord_reset,
    output logic [3:0] sw_stable
);

    localparam logic [CNT_W-1:0] CHORD_LAST = CNT_W'(CHORD_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [3:0]       sw_raw;
    logic [3:0]       stable_w;
    logic [3:0]       stable_prev_q;
    logic [3:0]       press;
    logic             all_high;
    logic             none_high;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [3:0]       move_q;
    logic [3:0]       move_d;
    logic             chord_q;
    logic             chord_d;
    logic [CNT_W-1:0] chord_cnt_q;
    logic [CNT_W-1:0] chord_cnt_d;
    logic             rep_fire;

    assign sw_raw = {switch4, switch3, switch2, switch1};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_deb
            switch_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_deb (
                .clk      (clk),
                .reset    (reset),
                .sw_raw   (sw_raw[gi]),
                .sw_stable(stable_w[gi])
            );
        end
    endgenerate

    // A press is a 0->1 change of a debounced level.
    assign press     = stable_w & ~stable_prev_q;
    assign all_high  = &stable_w;
    assign none_high = ~|stable_w;

`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             stable_changed;
    logic [CNT_W-1:0] rep_cnt_q;
    logic [CNT_W-1:0] rep_cnt_d;
    logic             rep_after_first_q;
    logic             rep_after_first_d;

    assign stable_changed = (stable_w != stable_prev_q);

    // Repeat timer: runs only while exactly one switch is held in HELD and
    // restarts on any level change; first gap is the delay, then the period.
    always_comb begin
        rep_fire          = 1'b0;
        rep_cnt_d         = rep_cnt_q;
        rep_after_first_d = rep_after_first_q;
        if (stable_changed || (state_q != HELD) || !$onehot(stable_w)) begin
            rep_cnt_d         = '0;
            rep_after_first_d = 1'b0;
        end else if (rep_after_first_q ? (rep_cnt_q >= REP_PERIOD_LAST)
                                       : (rep_cnt_q >= REP_DELAY_LAST)) begin
            rep_fire          = 1'b1;
            rep_cnt_d         = '0;
            rep_after_first_d = 1'b1;
        end else if (rep_cnt_q != '1) begin
            rep_cnt_d = rep_cnt_q + CNT_ONE;
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt_q         <= '0;
            rep_after_first_q <= 1'b0;
        end else begin
            rep_cnt_q         <= rep_cnt_d;
            rep_after_first_q <= rep_after_first_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Chord timer: counts consecutive cycles with all four stable-high,
    // held at zero during lockout so a long hold cannot re-trigger.
    always_comb begin
        chord_cnt_d = chord_cnt_q;
        if (!all_high || (state_q == LOCKOUT)) begin
            chord_cnt_d = '0;
        end else if (chord_cnt_q != '1) begin
            chord_cnt_d = chord_cnt_q + CNT_ONE;
        end
    end

    // Command FSM: decides the next state and the pulses to register.
    always_comb begin
        state_d = state_q;
        move_d  = 4'b0000;
        chord_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (all_high) begin
                    state_d = CHORD_WAIT;
                end else if (|press) begin
                    move_d  = priority_pick(press);
                    state_d = HELD;
                end else if (!none_high) begin
                    state_d = HELD;
                end
            end
            HELD: begin
                if (all_high) begin
                    // The switch completing a chord never moves the frog.
                    state_d = CHORD_WAIT;
                end else if (none_high) begin
                    state_d = IDLE;
                end else if (|press) begin
                    move_d = priority_pick(press);
                end else if (rep_fire) begin
                    move_d = stable_w;
                end
            end
            CHORD_WAIT: begin
                if (!all_high) begin
                    state_d = none_high ? IDLE : HELD;
                end else if (chord_cnt_q >= CHORD_LAST) begin
                    chord_d = 1'b1;
                    state_d = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (none_high) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, edge history, chord timer and registered output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            stable_prev_q <= 4'b0000;
            chord_cnt_q   <= '0;
            move_q        <= 4'b0000;
            chord_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            stable_prev_q <= stable_w;
            chord_cnt_q   <= chord_cnt_d;
            move_q        <= move_d;
            chord_q       <= chord_d;
        end
    end

    assign move_up     = move_q[DIR_UP];
    assign move_down   = move_q[DIR_DOWN];
    assign move_left   = move_q[DIR_LEFT];
    assign move_right  = move_q[DIR_RIGHT];
    assign chord_reset = chord_q;
    assign sw_stable   = stable_w;

endmodule
